// File: rtl/spi_arb_9361.sv
`default_nettype none
// ----------------------------------------------------------------------
// spi_arb_9361 : shares one AD9361 SPI master among N_REQ requesters
// Rev 1.0
// ----------------------------------------------------------------------
module spi_arb_9361 #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pri_mode,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    req_wr,
  input  logic [N_REQ*10-1:0] req_addr,
  input  logic [N_REQ*8-1:0]  req_wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic [N_REQ-1:0]    err,
  output logic [7:0]          rdata,
  output logic                busy,
  output logic [7:0]          err_cnt,
  output logic                spi_start,
  output logic                spi_wr,
  output logic [9:0]          spi_addr,
  output logic [7:0]          spi_wdata,
  input  logic                spi_busy,
  input  logic                spi_done,
  input  logic [7:0]          spi_rdata
);

  localparam int            PW       = $clog2(N_REQ);
  localparam logic [PW:0]   N_W      = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LAST     = PW'(N_REQ-1);
  localparam logic [15:0]   TMO_LAST = 16'(TIMEOUT-1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    own_q, own_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             tmo_q, tmo_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             spi_wr_q, spi_wr_d;
  logic [9:0]       spi_addr_q, spi_addr_d;
  logic [7:0]       spi_wdata_q, spi_wdata_d;

  logic [9:0] addr_a  [N_REQ];
  logic [7:0] wdata_a [N_REQ];

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
    assign addr_a[gi]  = req_addr[10*gi +: 10];
    assign wdata_a[gi] = req_wdata[8*gi +: 8];
  end

  // Winner selection: rotate from ptr; requester 0 is removed from the
  // rotation in priority mode because it has already been considered.
  logic [N_REQ-1:0] cand_mask;
  logic             win_vld;
  logic [PW-1:0]    win_idx;
  logic [PW:0]      scan;

  always_comb begin
    cand_mask = pri_mode ? (req & ~N_REQ'(1)) : req;
    win_vld   = 1'b0;
    win_idx   = '0;
    scan      = '0;
    if (pri_mode && req[0]) begin
      win_vld = 1'b1;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        scan = {1'b0, ptr_q} + (PW+1)'(k);
        if (scan >= N_W) scan = scan - N_W;
        if (!win_vld && cand_mask[scan[PW-1:0]]) begin
          win_vld = 1'b1;
          win_idx = scan[PW-1:0];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    gnt_d       = gnt_q;
    tmo_d       = tmo_q;
    cnt_d       = cnt_q;
    rdata_d     = rdata_q;
    err_cnt_d   = err_cnt_q;
    spi_wr_d    = spi_wr_q;
    spi_addr_d  = spi_addr_q;
    spi_wdata_d = spi_wdata_q;
    spi_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          own_d       = win_idx;
          gnt_d       = N_REQ'(1) << win_idx;
          spi_wr_d    = req_wr[win_idx];
          spi_addr_d  = addr_a[win_idx];
          spi_wdata_d = wdata_a[win_idx];
          tmo_d       = 1'b0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (!spi_busy) begin
          spi_start = 1'b1;
          // Counter holds cycles elapsed since the start strobe.
          cnt_d     = 16'd1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (spi_done) begin
          rdata_d = spi_rdata;
          state_d = RESP;
        end else if (cnt_q >= TMO_LAST) begin
          tmo_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (tmo_q && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        ptr_d   = (own_q == LAST) ? '0 : own_q + PW'(1);
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      gnt_q       <= '0;
      tmo_q       <= 1'b0;
      cnt_q       <= '0;
      rdata_q     <= '0;
      err_cnt_q   <= '0;
      spi_wr_q    <= 1'b0;
      spi_addr_q  <= '0;
      spi_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      gnt_q       <= gnt_d;
      tmo_q       <= tmo_d;
      cnt_q       <= cnt_d;
      rdata_q     <= rdata_d;
      err_cnt_q   <= err_cnt_d;
      spi_wr_q    <= spi_wr_d;
      spi_addr_q  <= spi_addr_d;
      spi_wdata_q <= spi_wdata_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = (state_q == RESP) ? gnt_q : '0;
  assign err       = ((state_q == RESP) && tmo_q) ? gnt_q : '0;
  assign rdata     = rdata_q;
  assign busy      = (state_q != IDLE);
  assign err_cnt   = err_cnt_q;
  assign spi_wr    = spi_wr_q;
  assign spi_addr  = spi_addr_q;
  assign spi_wdata = spi_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_arb_9361.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_spi_arb_9361 : randomized and directed bench for spi_arb_9361
// Rev 1.0
// ----------------------------------------------------------------------
module tb_spi_arb_9361;

  localparam int N   = 3;
  localparam int TMO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           pri_mode = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   req_wr = '0;
  logic [N*10-1:0] req_addr;
  logic [N*8-1:0] req_wdata;
  logic [N-1:0]   gnt, done, err;
  logic [7:0]     rdata, err_cnt;
  logic           busy, spi_start, spi_wr;
  logic [9:0]     spi_addr;
  logic [7:0]     spi_wdata;
  logic           spi_busy = 1'b0;
  logic           spi_done = 1'b0;
  logic [7:0]     spi_rdata = 8'h00;

  logic [9:0] addr_a  [N];
  logic [7:0] wdata_a [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign req_addr[10*i +: 10] = addr_a[i];
    assign req_wdata[8*i +: 8]  = wdata_a[i];
  end

  spi_arb_9361 #(.N_REQ(N), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pri_mode(pri_mode),
    .req(req), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .err_cnt(err_cnt), .spi_start(spi_start), .spi_wr(spi_wr),
    .spi_addr(spi_addr), .spi_wdata(spi_wdata), .spi_busy(spi_busy),
    .spi_done(spi_done), .spi_rdata(spi_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int         ptr_m = 0;
  logic [7:0] rdata_m = 8'h00;
  logic [7:0] err_cnt_m = 8'h00;

  typedef struct {
    logic [N-1:0] g;
    logic         w;
    logic [9:0]   a;
    logic [7:0]   wd;
    int           s;
    int           d;
    logic         st2;
    logic [N-1:0] dn;
    logic [N-1:0] er;
    logic [7:0]   rd;
  } txn_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Arbitration rule: requester 0 first in priority mode, otherwise the
  // first requesting index found walking upward (mod N) from the pointer.
  function automatic int model_winner(logic [N-1:0] r, logic p, int ptr);
    logic [N-1:0] sh;
    if (p && r[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j  = (ptr + k) % N;
      sh = r >> j;
      if (sh[0] && !(p && j == 0)) return j;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(int idx);
    return N'(1) << idx;
  endfunction

  // Acts as the SPI master for one transaction: waits for the start strobe,
  // answers after lat cycles (or never when hang), then waits for done.
  task automatic do_txn(input int lat, input logic [7:0] rd, input bit hang,
                        input bit drop, output txn_t t);
    int guard;
    guard = 0;
    while (spi_start !== 1'b1 && guard < 60) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (spi_start !== 1'b1) begin
      n_bad++;
      $display("FAIL start_wait: spi_start=%b want 1 within 60 cycles", spi_start);
    end
    t.s  = cyc;
    t.g  = gnt;
    t.w  = spi_wr;
    t.a  = spi_addr;
    t.wd = spi_wdata;
    if (drop) req = '0;
    tick();
    t.st2 = spi_start;
    if (!hang) begin
      repeat (lat - 1) tick();
      spi_done  = 1'b1;
      spi_rdata = rd;
      tick();
      spi_done  = 1'b0;
      spi_rdata = 8'($urandom);
    end
    guard = 0;
    while (done === '0 && guard < TMO + 10) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (done === '0) begin
      n_bad++;
      $display("FAIL done_wait: done=%b want nonzero within %0d cycles", done, TMO + 10);
    end
    t.d  = cyc;
    t.dn = done;
    t.er = err;
    t.rd = rdata;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #2 rst = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({gnt, done, err, busy, spi_start, spi_wr} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want 0", {gnt, done, err, busy, spi_start, spi_wr});
    end
    n_cmp++;
    if ({rdata, err_cnt, spi_addr, spi_wdata} !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got %h want 0", {rdata, err_cnt, spi_addr, spi_wdata});
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_idle: busy=%b want 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int   exp_seq[4] = '{0, 1, 2, 0};
    int   prev_s;
    txn_t t;
    pri_mode = 1'b0;
    req      = 3'b111;
    prev_s   = 0;
    for (int i = 0; i < 4; i++) begin
      do_txn(1, 8'(8'h10 + i), 1'b0, 1'b0, t);
      n_cmp++;
      if (t.g !== onehot(exp_seq[i]) || t.dn !== onehot(exp_seq[i])) begin
        n_bad++;
        $display("FAIL rr_order[%0d]: gnt=%b done=%b want %b", i, t.g, t.dn, onehot(exp_seq[i]));
      end
      if (i > 0) begin
        n_cmp++;
        if (t.s - prev_s !== 4) begin
          n_bad++;
          $display("FAIL rr_occupancy[%0d]: got %0d cycles want 4", i, t.s - prev_s);
        end
      end
      prev_s  = t.s;
      ptr_m   = (exp_seq[i] + 1) % N;
      rdata_m = 8'(8'h10 + i);
      if (i == 3) req = '0;
    end
    tick();
  endtask

  task automatic test_priority();
    int   exp_seq[4] = '{1, 2, 1, 2};
    txn_t t;
    pri_mode = 1'b1;
    req      = 3'b111;
    for (int i = 0; i < 4; i++) begin
      do_txn(2, 8'h20, 1'b0, 1'b0, t);
      n_cmp++;
      if (t.g !== 3'b001) begin
        n_bad++;
        $display("FAIL pri_req0[%0d]: gnt=%b want 001", i, t.g);
      end
      ptr_m = 1;
      if (i == 3) req = 3'b110;
    end
    for (int i = 0; i < 4; i++) begin
      do_txn(2, 8'h21, 1'b0, 1'b0, t);
      n_cmp++;
      if (t.g !== onehot(exp_seq[i])) begin
        n_bad++;
        $display("FAIL pri_rest[%0d]: gnt=%b want %b", i, t.g, onehot(exp_seq[i]));
      end
      ptr_m = (exp_seq[i] + 1) % N;
      if (i == 3) req = '0;
    end
    rdata_m  = 8'h21;
    pri_mode = 1'b0;
    tick();
  endtask

  task automatic test_single_write();
    txn_t t;
    int   t0;
    addr_a[1]  = 10'h014;
    wdata_a[1] = 8'h1A;
    req_wr     = 3'b010;
    t0         = cyc;
    req        = 3'b010;
    do_txn(5, 8'h5C, 1'b0, 1'b0, t);
    n_cmp++;
    if (t.s - t0 !== 1 || t.g !== 3'b010) begin
      n_bad++;
      $display("FAIL wr_grant: latency=%0d gnt=%b want 1 / 010", t.s - t0, t.g);
    end
    n_cmp++;
    if ({t.w, t.a, t.wd} !== {1'b1, 10'h014, 8'h1A}) begin
      n_bad++;
      $display("FAIL wr_fields: got %b/%h/%h want 1/014/1a", t.w, t.a, t.wd);
    end
    n_cmp++;
    if (t.st2 !== 1'b0) begin
      n_bad++;
      $display("FAIL wr_start_pulse: spi_start after start=%b want 0", t.st2);
    end
    n_cmp++;
    if (t.d - t.s !== 6 || t.dn !== 3'b010 || t.er !== 3'b000) begin
      n_bad++;
      $display("FAIL wr_done: delay=%0d done=%b err=%b want 6/010/000", t.d - t.s, t.dn, t.er);
    end
    ptr_m   = 2;
    rdata_m = 8'h5C;
    req     = '0;
    tick();
    n_cmp++;
    if (done !== '0 || gnt !== '0) begin
      n_bad++;
      $display("FAIL wr_release: done=%b gnt=%b want 0/0", done, gnt);
    end
  endtask

  task automatic test_read();
    txn_t t;
    addr_a[2] = 10'h037;
    req_wr    = 3'b000;
    req       = 3'b100;
    do_txn(3, 8'hA5, 1'b0, 1'b0, t);
    n_cmp++;
    if ({t.g, t.w, t.a} !== {3'b100, 1'b0, 10'h037}) begin
      n_bad++;
      $display("FAIL rd_fields: gnt=%b wr=%b addr=%h want 100/0/037", t.g, t.w, t.a);
    end
    n_cmp++;
    if (t.rd !== 8'hA5 || t.dn !== 3'b100) begin
      n_bad++;
      $display("FAIL rd_data: rdata=%h done=%b want a5/100", t.rd, t.dn);
    end
    ptr_m   = 0;
    rdata_m = 8'hA5;
    req     = '0;
    repeat (5) tick();
    n_cmp++;
    if (rdata !== 8'hA5) begin
      n_bad++;
      $display("FAIL rd_hold: rdata=%h want a5", rdata);
    end
  endtask

  task automatic test_timeout();
    txn_t t;
    req = 3'b001;
    do_txn(1, 8'h00, 1'b1, 1'b0, t);
    n_cmp++;
    if (t.d - t.s !== TMO || t.dn !== 3'b001 || t.er !== 3'b001) begin
      n_bad++;
      $display("FAIL tmo_abort: delay=%0d done=%b err=%b want %0d/001/001", t.d - t.s, t.dn, t.er, TMO);
    end
    n_cmp++;
    if (t.rd !== rdata_m) begin
      n_bad++;
      $display("FAIL tmo_rdata: rdata=%h want %h", t.rd, rdata_m);
    end
    err_cnt_m = err_cnt_m + 8'd1;
    ptr_m     = 1;
    tick();
    n_cmp++;
    if (err_cnt !== err_cnt_m) begin
      n_bad++;
      $display("FAIL tmo_errcnt: err_cnt=%0d want %0d", err_cnt, err_cnt_m);
    end
    // requester 0 is still requesting; pointer 1 wraps round to it
    do_txn(TMO - 1, 8'h3C, 1'b0, 1'b0, t);
    n_cmp++;
    if (t.d - t.s !== TMO || t.er !== 3'b000 || t.dn !== 3'b001 || t.rd !== 8'h3C) begin
      n_bad++;
      $display("FAIL tmo_tie: delay=%0d err=%b done=%b rdata=%h want %0d/000/001/3c",
               t.d - t.s, t.er, t.dn, t.rd, TMO);
    end
    rdata_m = 8'h3C;
    ptr_m   = 1;
    req     = '0;
    tick();
    n_cmp++;
    if (err_cnt !== err_cnt_m) begin
      n_bad++;
      $display("FAIL tie_errcnt: err_cnt=%0d want %0d", err_cnt, err_cnt_m);
    end
  endtask

  task automatic test_busy();
    txn_t t;
    spi_busy = 1'b1;
    req      = 3'b010;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (spi_start !== 1'b0 || gnt !== 3'b010 || busy !== 1'b1) begin
        n_bad++;
        $display("FAIL busy_hold[%0d]: start=%b gnt=%b busy=%b want 0/010/1", i, spi_start, gnt, busy);
      end
    end
    spi_busy = 1'b0;
    #1;
    n_cmp++;
    if (spi_start !== 1'b1) begin
      n_bad++;
      $display("FAIL busy_release: spi_start=%b want 1", spi_start);
    end
    do_txn(2, 8'h77, 1'b0, 1'b0, t);
    n_cmp++;
    if (t.dn !== 3'b010) begin
      n_bad++;
      $display("FAIL busy_done: done=%b want 010", t.dn);
    end
    ptr_m   = 2;
    rdata_m = 8'h77;
    req     = '0;
    tick();
  endtask

  task automatic test_random();
    txn_t         t;
    logic [N-1:0] r;
    int           w, lat;
    bit           hang, drop;
    logic [7:0]   rd;
    logic [N-1:0] eg;
    for (int it = 0; it < 24; it++) begin
      for (int i = 0; i < N; i++) begin
        addr_a[i]  = 10'($urandom);
        wdata_a[i] = 8'($urandom);
      end
      req_wr = N'($urandom);
      do r = N'($urandom); while (r == '0);
      pri_mode = 1'($urandom);
      req      = r;
      w    = model_winner(r, pri_mode, ptr_m);
      eg   = onehot(w);
      hang = ($urandom_range(0, 4) == 0);
      drop = ($urandom_range(0, 3) == 0);
      lat  = $urandom_range(1, TMO - 1);
      rd   = 8'($urandom);
      do_txn(lat, rd, hang, drop, t);
      n_cmp++;
      if (t.g !== eg || t.dn !== eg) begin
        n_bad++;
        $display("FAIL rnd_grant[%0d]: gnt=%b done=%b want %b", it, t.g, t.dn, eg);
      end
      n_cmp++;
      if ({t.w, t.a, t.wd} !== {req_wr[w], addr_a[w], wdata_a[w]}) begin
        n_bad++;
        $display("FAIL rnd_fields[%0d]: got %b/%h/%h want %b/%h/%h", it, t.w, t.a, t.wd,
                 req_wr[w], addr_a[w], wdata_a[w]);
      end
      n_cmp++;
      if (t.d - t.s !== (hang ? TMO : lat + 1) || t.er !== (hang ? eg : '0) || t.st2 !== 1'b0) begin
        n_bad++;
        $display("FAIL rnd_timing[%0d]: delay=%0d err=%b st2=%b want %0d/%b/0", it, t.d - t.s,
                 t.er, t.st2, hang ? TMO : lat + 1, hang ? eg : '0);
      end
      if (hang) begin
        if (err_cnt_m != 8'hFF) err_cnt_m = err_cnt_m + 8'd1;
      end else begin
        rdata_m = rd;
      end
      ptr_m = (w + 1) % N;
      n_cmp++;
      if (t.rd !== rdata_m) begin
        n_bad++;
        $display("FAIL rnd_rdata[%0d]: rdata=%h want %h", it, t.rd, rdata_m);
      end
      req = '0;
      tick();
      n_cmp++;
      if (err_cnt !== err_cnt_m || done !== '0 || gnt !== '0) begin
        n_bad++;
        $display("FAIL rnd_after[%0d]: err_cnt=%0d done=%b gnt=%b want %0d/000/000", it,
                 err_cnt, done, gnt, err_cnt_m);
      end
    end
    pri_mode = 1'b0;
  endtask

  task automatic test_reset_midflight();
    txn_t t;
    int   guard;
    req   = 3'b100;
    guard = 0;
    while (spi_start !== 1'b1 && guard < 20) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_inflight: busy=%b want 1", busy);
    end
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({gnt, done, err, busy, spi_start, spi_wr, rdata, err_cnt, spi_addr, spi_wdata} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: outputs=%h want 0",
               {gnt, done, err, busy, spi_start, spi_wr, rdata, err_cnt, spi_addr, spi_wdata});
    end
    tick();
    n_cmp++;
    if (done !== '0) begin
      n_bad++;
      $display("FAIL mid_nodone: done=%b want 000", done);
    end
    rst       = 1'b0;
    ptr_m     = 0;
    rdata_m   = 8'h00;
    err_cnt_m = 8'h00;
    pri_mode  = 1'b0;
    req       = 3'b111;
    do_txn(2, 8'h42, 1'b0, 1'b0, t);
    n_cmp++;
    if (t.g !== onehot(model_winner(3'b111, 1'b0, 0)) || t.dn !== 3'b001) begin
      n_bad++;
      $display("FAIL mid_restart: gnt=%b done=%b want 001/001", t.g, t.dn);
    end
    req = '0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      addr_a[i]  = '0;
      wdata_a[i] = '0;
    end
    test_reset();
    test_round_robin();
    test_priority();
    test_single_write();
    test_read();
    test_timeout();
    test_busy();
    test_random();
    test_reset_midflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
